// File: rtl/bus_pkg.sv
// Shared helpers for the bus crossbar slice.
package bus_pkg;

    // Index width for an n-entry array; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Maps a byte address onto the lowest-indexed device whose base/mask window matches.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int AddressWidth = 32,
    parameter int DevIdxW      = idx_width(NrDevices)
) (
    input  logic [AddressWidth-1:0] addr,
    input  logic [AddressWidth-1:0] base [NrDevices],
    input  logic [AddressWidth-1:0] mask [NrDevices],
    output logic [DevIdxW-1:0]      device_sel,
    output logic                    unmapped
);

    // Scan downwards so that the lowest matching index is the last one written.
    always_comb begin
        device_sel = '0;
        unmapped   = 1'b1;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((addr & mask[d]) == base[d]) begin
                device_sel = DevIdxW'(d);
                unmapped   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus.sv
// Fixed-priority host-to-device crossbar with one-cycle response routing.
module bus
    import bus_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i    [NrHosts],
    output logic                      host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
    input  logic                      host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
    output logic                      host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
    output logic                      host_err_o    [NrHosts],

    output logic                      device_req_o    [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
    output logic                      device_we_o     [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
    input  logic                      device_rvalid_i [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
    input  logic                      device_err_i    [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int HostIdxW = idx_width(NrHosts);
    localparam int DevIdxW  = idx_width(NrDevices);

    logic [HostIdxW-1:0] host_sel;
    logic                host_valid;
    logic [DevIdxW-1:0]  device_sel;
    logic                unmapped;

    logic [HostIdxW-1:0] host_sel_q;
    logic [DevIdxW-1:0]  device_sel_q;
    logic                unmapped_q;

    always_comb begin
        host_sel   = '0;
        host_valid = 1'b0;
        for (int h = NrHosts - 1; h >= 0; h--) begin
            if (host_req_i[h]) begin
                host_sel   = HostIdxW'(h);
                host_valid = 1'b1;
            end
        end
    end

    bus_addr_decoder #(
        .NrDevices    (NrDevices),
        .AddressWidth (AddressWidth),
        .DevIdxW      (DevIdxW)
    ) u_addr_decoder (
        .addr       (host_addr_i[host_sel]),
        .base       (cfg_device_addr_base),
        .mask       (cfg_device_addr_mask),
        .device_sel (device_sel),
        .unmapped   (unmapped)
    );

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = host_valid && (host_sel == HostIdxW'(h));
        end
    end

    // Payload fans out to every device; only req qualifies it.
    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = host_valid && !unmapped && (device_sel == DevIdxW'(d));
            device_addr_o[d]  = host_addr_i[host_sel];
            device_we_o[d]    = host_we_i[host_sel];
            device_be_o[d]    = host_be_i[host_sel];
            device_wdata_o[d] = host_wdata_i[host_sel];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            host_sel_q   <= '0;
            device_sel_q <= '0;
            unmapped_q   <= 1'b0;
        end else if (host_valid) begin
            host_sel_q   <= host_sel;
            device_sel_q <= device_sel;
            unmapped_q   <= unmapped;
        end else begin
            unmapped_q   <= 1'b0;
        end
    end

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (host_sel_q == HostIdxW'(h)) begin
                host_rvalid_o[h] = device_rvalid_i[device_sel_q] | unmapped_q;
                host_rdata_o[h]  = unmapped_q ? '0 : device_rdata_i[device_sel_q];
                host_err_o[h]    = device_err_i[device_sel_q] | unmapped_q;
            end
        end
    end

endmodule

// File: tb/tb_bus.sv
// Directed and random checks of the bus crossbar against a transaction-level model.
module tb_bus;

    localparam int NH = 2;
    localparam int ND = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;

    logic          host_req_i    [NH];
    logic          host_gnt_o    [NH];
    logic [AW-1:0] host_addr_i   [NH];
    logic          host_we_i     [NH];
    logic [BW-1:0] host_be_i     [NH];
    logic [DW-1:0] host_wdata_i  [NH];
    logic          host_rvalid_o [NH];
    logic [DW-1:0] host_rdata_o  [NH];
    logic          host_err_o    [NH];

    logic          device_req_o    [ND];
    logic [AW-1:0] device_addr_o   [ND];
    logic          device_we_o     [ND];
    logic [BW-1:0] device_be_o     [ND];
    logic [DW-1:0] device_wdata_o  [ND];
    logic          device_rvalid_i [ND];
    logic [DW-1:0] device_rdata_i  [ND];
    logic          device_err_i    [ND];

    logic [AW-1:0] cfg_device_addr_base [ND];
    logic [AW-1:0] cfg_device_addr_mask [ND];

    logic [DW-1:0] resp_data [ND];
    logic          resp_err  [ND];

    int n_assert = 0;
    int n_fail   = 0;

    bit            pend_v;
    int            pend_h;
    bit            pend_unm;
    logic [DW-1:0] pend_data;
    bit            pend_err;

    bus #(
        .NrDevices    (ND),
        .NrHosts      (NH),
        .DataWidth    (DW),
        .AddressWidth (AW)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .host_req_i           (host_req_i),
        .host_gnt_o           (host_gnt_o),
        .host_addr_i          (host_addr_i),
        .host_we_i            (host_we_i),
        .host_be_i            (host_be_i),
        .host_wdata_i         (host_wdata_i),
        .host_rvalid_o        (host_rvalid_o),
        .host_rdata_o         (host_rdata_o),
        .host_err_o           (host_err_o),
        .device_req_o         (device_req_o),
        .device_addr_o        (device_addr_o),
        .device_we_o          (device_we_o),
        .device_be_o          (device_be_o),
        .device_wdata_o       (device_wdata_o),
        .device_rvalid_i      (device_rvalid_i),
        .device_rdata_i       (device_rdata_i),
        .device_err_i         (device_err_i),
        .cfg_device_addr_base (cfg_device_addr_base),
        .cfg_device_addr_mask (cfg_device_addr_mask)
    );

    always #5 clk_i = ~clk_i;

    // One-cycle responders: answer exactly the cycle after a req is seen.
    always @(posedge clk_i or negedge rst_ni) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_ni) begin
                device_rvalid_i[d] <= 1'b0;
                device_rdata_i[d]  <= '0;
                device_err_i[d]    <= 1'b0;
            end else begin
                device_rvalid_i[d] <= device_req_o[d];
                device_rdata_i[d]  <= device_req_o[d] ? resp_data[d] : '0;
                device_err_i[d]    <= device_req_o[d] & resp_err[d];
            end
        end
    end

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int d = 0; d < ND; d++)
            if ((a & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) return d;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_host(input int h, input bit req, input logic [AW-1:0] addr,
                            input bit we, input logic [BW-1:0] be, input logic [DW-1:0] wd);
        host_req_i[h]   = req;
        host_addr_i[h]  = addr;
        host_we_i[h]    = we;
        host_be_i[h]    = be;
        host_wdata_i[h] = wd;
    endtask

    task automatic idle_hosts();
        for (int h = 0; h < NH; h++) set_host(h, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_resp();
        bit ev;
        for (int h = 0; h < NH; h++) begin
            ev = pend_v && (pend_h == h);
            chk($sformatf("rvalid[%0d]", h), 64'(host_rvalid_o[h]), 64'(ev));
            chk($sformatf("rdata[%0d]", h), 64'(host_rdata_o[h]),
                (ev && !pend_unm) ? 64'(pend_data) : 64'd0);
            chk($sformatf("err[%0d]", h), 64'(host_err_o[h]), 64'(ev && pend_err));
        end
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic cycle();
        int win;
        int dev;
        #1;
        win = -1;
        for (int h = 0; h < NH; h++) if (host_req_i[h] && win < 0) win = h;
        dev = (win >= 0) ? ref_decode(host_addr_i[win]) : -1;
        for (int h = 0; h < NH; h++)
            chk($sformatf("gnt[%0d]", h), 64'(host_gnt_o[h]), 64'(win == h));
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("dev_req[%0d]", d), 64'(device_req_o[d]), 64'(win >= 0 && dev == d));
            if (win >= 0 && dev == d) begin
                chk($sformatf("dev_addr[%0d]", d), 64'(device_addr_o[d]), 64'(host_addr_i[win]));
                chk($sformatf("dev_we[%0d]", d), 64'(device_we_o[d]), 64'(host_we_i[win]));
                chk($sformatf("dev_be[%0d]", d), 64'(device_be_o[d]), 64'(host_be_i[win]));
                chk($sformatf("dev_wdata[%0d]", d), 64'(device_wdata_o[d]), 64'(host_wdata_i[win]));
            end
        end
        @(posedge clk_i);
        pend_v    = (win >= 0);
        pend_h    = win;
        pend_unm  = (win >= 0) && (dev < 0);
        pend_data = (dev >= 0) ? resp_data[dev] : '0;
        pend_err  = (dev < 0) ? 1'b1 : resp_err[dev];
        #1;
        check_resp();
        @(negedge clk_i);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h0010_0000 + 32'($urandom_range(0, 32'hF_FFFF));
            1:       return 32'h0002_0000 + 32'($urandom_range(0, 32'h3FF));
            2:       return 32'h0003_0000 + 32'($urandom_range(0, 32'h3FF));
            3:       return 32'h0090_0000 + 32'($urandom_range(0, 32'hFFF));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = ~32'h000F_FFFF;
        cfg_device_addr_base[1] = 32'h0002_0000; cfg_device_addr_mask[1] = ~32'h0000_03FF;
        cfg_device_addr_base[2] = 32'h0003_0000; cfg_device_addr_mask[2] = ~32'h0000_03FF;
        for (int d = 0; d < ND; d++) begin
            resp_data[d] = '0;
            resp_err[d]  = 1'b0;
        end
        idle_hosts();
        pend_v = 0; pend_h = -1; pend_unm = 0; pend_data = '0; pend_err = 0;

        repeat (3) @(negedge clk_i);
        check_resp();
        for (int d = 0; d < ND; d++)
            chk($sformatf("reset_dev_req[%0d]", d), 64'(device_req_o[d]), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // single read
        resp_data[0] = 32'hDEAD_BEEF;
        set_host(0, 1'b1, 32'h0010_0010, 1'b0, 4'hF, '0);
        cycle();
        chk("read_rdata", 64'(host_rdata_o[0]), 64'h0000_0000_DEAD_BEEF);
        idle_hosts();
        cycle();

        // write decode
        resp_data[1] = 32'h0000_1111;
        set_host(0, 1'b1, 32'h0002_0004, 1'b1, 4'hF, 32'h41);
        cycle();
        idle_hosts();
        cycle();

        // contention: host1 waits one cycle
        resp_data[0] = 32'hA5A5_0000;
        resp_data[2] = 32'h5A5A_0002;
        set_host(0, 1'b1, 32'h0010_0100, 1'b0, 4'hF, '0);
        set_host(1, 1'b1, 32'h0003_0008, 1'b0, 4'h3, '0);
        cycle();
        set_host(0, 1'b0, '0, 1'b0, '0, '0);
        cycle();
        idle_hosts();
        cycle();

        // unmapped
        set_host(1, 1'b1, 32'h0090_0000, 1'b0, 4'hF, '0);
        cycle();
        chk("unmapped_err", 64'(host_err_o[1]), 64'd1);
        idle_hosts();
        cycle();

        // back-to-back with a device error on the first
        resp_data[2] = 32'h2222_2222; resp_err[2] = 1'b1;
        set_host(0, 1'b1, 32'h0003_0000, 1'b0, 4'hF, '0);
        cycle();
        resp_data[0] = 32'h0000_0D00; resp_err[2] = 1'b0;
        set_host(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, '0);
        cycle();
        idle_hosts();
        cycle();

        // reset with a response in flight
        resp_data[1] = 32'hBAD0_BAD0;
        set_host(0, 1'b1, 32'h0002_0010, 1'b0, 4'hF, '0);
        #1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        idle_hosts();
        pend_v = 0;
        #1;
        check_resp();
        for (int d = 0; d < ND; d++)
            chk($sformatf("rst_dev_req[%0d]", d), 64'(device_req_o[d]), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle();
        resp_data[1] = 32'h1234_5678;
        set_host(1, 1'b1, 32'h0002_0020, 1'b0, 4'hF, '0);
        cycle();
        idle_hosts();
        cycle();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            for (int d = 0; d < ND; d++) begin
                resp_data[d] = $urandom;
                resp_err[d]  = ($urandom_range(0, 7) == 0);
            end
            for (int h = 0; h < NH; h++)
                set_host(h, ($urandom_range(0, 9) < 6), rand_addr(), 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 15)), $urandom);
            cycle();
        end
        idle_hosts();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus.md
Name: bus

Overview:
- Single-level, combinational-request crossbar for the simple system.
- Arbitrates NrHosts hosts using fixed priority, where the lowest index wins.
- Decodes the winner's address into one of NrDevices memory-mapped devices using per-device base/mask pairs.
- Routes the one-cycle-later device response back to the originating host. Sits between the core data port and RAM, sim-control, timer and coprocessor devices.

Parameters:
- NrDevices, 1, number of device (slave) ports.
- NrHosts, 1, number of host (master) ports.
- DataWidth, 32, width of wdata/rdata.
- AddressWidth, 32, width of addresses, base and mask.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset: asynchronous, active-low. One clock domain.
- host_req_i  in  [NrHosts] x 1  request.
- host_gnt_o  out  [NrHosts] x 1  grant, combinational.
- host_addr_i  in  [NrHosts] x AddressWidth  byte address.
- host_we_i  in  [NrHosts] x 1  write enable.
- host_be_i  in  [NrHosts] x DataWidth/8  byte enables.
- host_wdata_i  in  [NrHosts] x DataWidth  write data.
- host_rvalid_o  out  [NrHosts] x 1  response valid.
- host_rdata_o  out  [NrHosts] x DataWidth  read data.
- host_err_o  out  [NrHosts] x 1  response error.
- device_req_o  out  [NrDevices] x 1  request.
- device_addr_o  out  [NrDevices] x AddressWidth  address.
- device_we_o  out  [NrDevices] x 1  write enable.
- device_be_o  out  [NrDevices] x DataWidth/8  byte enables.
- device_wdata_o  out  [NrDevices] x DataWidth  write data.
- device_rvalid_i  in  [NrDevices] x 1  response valid.
- device_rdata_i  in  [NrDevices] x DataWidth  read data.
- device_err_i  in  [NrDevices] x 1  response error.
- cfg_device_addr_base  in  [NrDevices] x AddressWidth  device base address.
- cfg_device_addr_mask  in  [NrDevices] x AddressWidth  device address mask.

All arrays are unpacked.

Behaviour:

Request arbitration
- host_sel is the lowest index i with host_req_i[i]=1. Combinational.
- host_gnt_o[host_sel] = 1; every other gnt = 0.
- No request means no grant and all device_req_o = 0.

Address decode
- device_sel is the lowest index d with (host_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d].
- Overlapping regions resolve to the lowest index.

Request forwarding
- On a granted request to a mapped address, device_req_o[device_sel]=1. Addr, we, be and wdata come from host_sel, combinationally, in the same cycle.
- Non-selected devices get req=0. Their addr/we/be/wdata are driven from host_sel as well, since these are don't-care.

Response routing
- On every cycle with a granted request, register host_sel_q, device_sel_q and unmapped_q. Otherwise hold host_sel_q and device_sel_q, and clear unmapped_q.
- Routing is combinational from these registers:
  - host_rvalid_o[host_sel_q] = device_rvalid_i[device_sel_q] | unmapped_q.
  - host_rdata_o[host_sel_q] = device_rdata_i[device_sel_q], or 0 when unmapped_q.
  - host_err_o[host_sel_q] = device_err_i[device_sel_q] | unmapped_q.
- All other hosts see rvalid=0, rdata=0, err=0.

Latency and handshake
- Devices must respond exactly one cycle after accepting a req. Host rvalid therefore arrives in cycle N+1 for a request granted in cycle N.
- Back-to-back requests every cycle are supported at full throughput.

Unmapped address
- The request is granted and no device_req is asserted.
- Next cycle: host_rvalid=1, host_err=1, rdata=0.

Simultaneous requests
- Only the winner is granted.
- Losers keep req high and are granted in a later cycle.

Reset
- host_sel_q=0, device_sel_q=0, unmapped_q=0. Hence all host_rvalid/err/rdata are 0 while device_rvalid_i are 0.
- Reset mid-transaction drops the pending response.

Decomposition:
- No shared package is required; widths come from parameters.
- One sub-module is natural: bus_addr_decoder. It is purely combinational: address, base and mask arrays in; device index and unmapped flag out.
- Everything else stays in bus.

Test Plan:
All scenarios use NrHosts=2 and NrDevices=3, with a 1-cycle responder model per device. Bases are 0x100000 (mask ~0xFFFFF), 0x20000 (mask ~0x3FF) and 0x30000 (mask ~0x3FF).

1. Single read: host0 req, addr 0x100010, we=0. Required: same-cycle gnt0=1, device_req[0]=1 with addr 0x100010. Device returns 0xDEADBEEF next cycle; required: host_rvalid[0]=1, rdata=0xDEADBEEF, err=0; host1 outputs 0.
2. Write decode: host0 write addr 0x20004, wdata 0x41, be 0xF. Required: only device_req[1]=1, with we=1, wdata 0x41, be 0xF.
3. Contention: host0 and host1 both req in the same cycle. Required: gnt0=1, gnt1=0. Next cycle, with host1 still requesting, gnt1=1 and host1's response arrives the cycle after that.
4. Unmapped: host1 req addr 0x900000. Required: gnt1=1 and no device_req; next cycle host_rvalid[1]=1, err=1, rdata=0.
5. Back-to-back: host0 reads 0x30000 then 0x100000 in consecutive cycles. Required: responses route from device2 then device0 to host0 on consecutive cycles. Device error: device_err[2]=1 propagates as host_err[0]=1.
6. Reset: assert rst_ni low while a response is pending. Required: all host_rvalid=0 and device_req=0 while there is no request; normal operation resumes after release.
